// File: rtl/seq_multiplier.sv
// seq_multiplier: W-cycle shift-and-add multiplier with start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to enable two's-complement operands via sgn.
module seq_multiplier #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   oprnd1,
  input  logic [W-1:0]   oprnd2,
  input  logic           sgn,
  output logic [2*W-1:0] prdct,
  output logic           busy,
  output logic           done
);
`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state;
  logic [W-1:0]   mcand, mplier, mag1, mag2;
  logic [W:0]     acc, sum;
  logic [CW-1:0]  cnt;
  logic           neg, sgn_en, ready;
  logic [2*W-1:0] raw;
  // With signing disabled sgn_en is constant 0, so the magnitude and negate paths fold away.
  always_comb begin
    ready  = state != RUN;
    sgn_en = sgn & SIGNED_EN;
    mag1   = (sgn_en & oprnd1[W-1]) ? -oprnd1 : oprnd1;
    mag2   = (sgn_en & oprnd2[W-1]) ? -oprnd2 : oprnd2;
    sum    = acc + (mplier[0] ? {1'b0, mcand} : '0);
    raw    = {sum, mplier[W-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      prdct  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (ready) begin
      state <= start ? RUN : IDLE;
      busy  <= start;
      done  <= 1'b0;
      if (start) begin
        mcand  <= mag1;
        mplier <= mag2;
        acc    <= '0;
        cnt    <= CW'(W);
        neg    <= sgn_en & (oprnd1[W-1] ^ oprnd2[W-1]);
      end
    end else begin
      acc    <= {1'b0, sum[W:1]};
      mplier <= {sum[0], mplier[W-1:1]};
      cnt    <= cnt - 1'b1;
      // Last step: load the shifted result directly so the product lands W edges after accept.
      if (cnt == CW'(1)) begin
        prdct <= neg ? -raw : raw;
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed self-checking bench for seq_multiplier with W=8.
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  oprnd1 = '0;
  logic [7:0]  oprnd2 = '0;
  logic        sgn = 1'b0;
  logic [15:0] prdct;
  logic        busy;
  logic        done;
  int          tests = 0;
  int          fails = 0;

  seq_multiplier #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .oprnd1(oprnd1), .oprnd2(oprnd2),
    .sgn(sgn), .prdct(prdct), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; oprnd1 = a; oprnd2 = b; sgn = s;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int lat, output int bcnt, output logic [15:0] p);
    issue(a, b, s);
    bcnt = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    p = prdct;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (prdct !== 16'h0000) begin fails++; $display("FAIL reset_prdct got %h expected 0000", prdct); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", done); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bcnt;
    logic [15:0] p;
    run_op(8'd13, 8'd11, 1'b0, lat, bcnt, p);
    tests++; if (lat !== 8) begin fails++; $display("FAIL basic_latency got %0d expected 8", lat); end
    tests++; if (bcnt !== 8) begin fails++; $display("FAIL basic_busy_cycles got %0d expected 8", bcnt); end
    tests++; if (p !== 16'h008F) begin fails++; $display("FAIL basic_prdct got %h expected 008f", p); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b expected 0", done); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (prdct !== 16'h008F) begin fails++; $display("FAIL basic_hold got %h expected 008f", prdct); end
  endtask

  task automatic test_max_zero;
    int lat, bcnt;
    logic [15:0] p;
    run_op(8'd255, 8'd255, 1'b0, lat, bcnt, p);
    tests++; if (p !== 16'hFE01) begin fails++; $display("FAIL max_prdct got %h expected fe01", p); end
    run_op(8'd0, 8'd200, 1'b0, lat, bcnt, p);
    tests++; if (p !== 16'h0000) begin fails++; $display("FAIL zero_prdct got %h expected 0000", p); end
    tests++; if (lat !== 8) begin fails++; $display("FAIL zero_latency got %0d expected 8", lat); end
  endtask

  task automatic test_back_to_back;
    int k, k1, k2, lat, bcnt;
    logic [15:0] p1, p2, p;
    k1 = 0; k2 = 0; p1 = '0; p2 = '0;
    @(negedge clk);
    start = 1'b1; oprnd1 = 8'd3; oprnd2 = 8'd4; sgn = 1'b0;
    @(posedge clk); #1;
    oprnd1 = 8'd5; oprnd2 = 8'd6;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 9) start = 1'b0;
      if (done && k1 == 0) begin k1 = k; p1 = prdct; end
      else if (done) begin k2 = k; p2 = prdct; end
    end
    tests++; if (k1 !== 8) begin fails++; $display("FAIL b2b_first_done got %0d expected 8", k1); end
    tests++; if (p1 !== 16'h000C) begin fails++; $display("FAIL b2b_first_prdct got %h expected 000c", p1); end
    tests++; if (k2 !== 17) begin fails++; $display("FAIL b2b_second_done got %0d expected 17", k2); end
    tests++; if (p2 !== 16'h001E) begin fails++; $display("FAIL b2b_second_prdct got %h expected 001e", p2); end
    issue(8'd2, 8'd3, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; oprnd1 = 8'd9; oprnd2 = 8'd9;
    @(posedge clk); #1 start = 1'b0;
    lat = 3;
    bcnt = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    p = prdct;
    tests++; if (lat !== 8) begin fails++; $display("FAIL ignored_start_latency got %0d expected 8", lat); end
    tests++; if (p !== 16'h0006) begin fails++; $display("FAIL ignored_start_prdct got %h expected 0006", p); end
    repeat (3) begin @(posedge clk); #1; if (busy) bcnt++; end
    tests++; if (bcnt !== 0) begin fails++; $display("FAIL ignored_start_no_rerun got %0d busy cycles expected 0", bcnt); end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt;
    logic [15:0] p;
    issue(8'd7, 8'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (prdct !== 16'h0000) begin fails++; $display("FAIL midrst_prdct got %h expected 0000", prdct); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrst_done got %b expected 0", done); end
    rst = 1'b0;
    bcnt = 0;
    repeat (10) begin @(posedge clk); #1; if (done || busy) bcnt++; end
    tests++; if (bcnt !== 0) begin fails++; $display("FAIL midrst_aborted_op got %0d active cycles expected 0", bcnt); end
    run_op(8'd2, 8'd2, 1'b0, lat, bcnt, p);
    tests++; if (p !== 16'h0004) begin fails++; $display("FAIL midrst_after_prdct got %h expected 0004", p); end
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed;
    int lat, bcnt;
    logic [15:0] p;
    run_op(8'hFD, 8'h07, 1'b1, lat, bcnt, p);
    tests++; if (p !== 16'hFFEB) begin fails++; $display("FAIL signed_neg3x7 got %h expected ffeb", p); end
    tests++; if (lat !== 8) begin fails++; $display("FAIL signed_latency got %0d expected 8", lat); end
    run_op(8'h80, 8'h80, 1'b1, lat, bcnt, p);
    tests++; if (p !== 16'h4000) begin fails++; $display("FAIL signed_min_min got %h expected 4000", p); end
    run_op(8'h80, 8'h7F, 1'b1, lat, bcnt, p);
    tests++; if (p !== 16'hC080) begin fails++; $display("FAIL signed_min_max got %h expected c080", p); end
    run_op(8'hFD, 8'h07, 1'b0, lat, bcnt, p);
    tests++; if (p !== 16'h06EB) begin fails++; $display("FAIL signed_sgn0 got %h expected 06eb", p); end
  endtask
`else
  task automatic test_sgn_ignored;
    int lat, bcnt;
    logic [15:0] p;
    run_op(8'hFD, 8'h07, 1'b1, lat, bcnt, p);
    tests++; if (p !== 16'h06EB) begin fails++; $display("FAIL sgn_ignored got %h expected 06eb", p); end
    run_op(8'h80, 8'h80, 1'b1, lat, bcnt, p);
    tests++; if (p !== 16'h4000) begin fails++; $display("FAIL sgn_ignored_80x80 got %h expected 4000", p); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_max_zero;
    test_back_to_back;
    test_reset_mid;
`ifdef SEQ_MULT_SIGNED_EN
    test_signed;
`else
    test_sgn_ignored;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
